// File: rtl/empty_ptr_fifo.sv
// Free-pointer pool: a circular FIFO preloaded with pointers 0..INIT_CNT-1.
// Consumers take the show-ahead head with an ack. Producers return freed
// pointers with an add strobe. Dropped adds and unmatched acks raise sticky
// error flags, which clear only on reset or reinit.
module empty_ptr_fifo #(
    parameter int A_WIDTH  = 8,
    parameter int INIT_CNT = 2**A_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               reinit_i,
    input  logic [A_WIDTH-1:0] add_empty_ptr_i,
    input  logic               add_empty_ptr_en_i,
    input  logic               next_empty_ptr_rd_ack_i,
    output logic [A_WIDTH-1:0] next_empty_ptr_o,
    output logic               next_empty_ptr_val_o,
    output logic [A_WIDTH:0]   empty_ptr_cnt_o,
    output logic               init_done_o,
    output logic               add_err_o,
    output logic               rd_err_o
);

    localparam int               DEPTH       = 2**A_WIDTH;
    localparam logic [A_WIDTH:0] C_DEPTH     = (A_WIDTH+1)'(DEPTH);
    localparam logic [A_WIDTH:0] C_INIT_LAST = (A_WIDTH+1)'(INIT_CNT - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic [A_WIDTH-1:0] r_mem [DEPTH];
    logic [A_WIDTH-1:0] r_rd_ptr, r_wr_ptr;
    logic [A_WIDTH:0]   r_cnt, w_cnt_nxt;
    logic [A_WIDTH:0]   r_init_cnt;
    logic               r_add_err, r_rd_err;
    logic               w_pop, w_push, w_wr_en;
    logic [A_WIDTH-1:0] w_wr_data;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_INIT;
        else          r_state <= w_state_nxt;
    end

    // Next state: reinit always returns to INIT; INIT leaves on its last preload write
    always_comb begin
        w_state_nxt = r_state;
        if (reinit_i)
            w_state_nxt = ST_INIT;
        else if (r_state == ST_INIT && r_init_cnt == C_INIT_LAST)
            w_state_nxt = ST_RUN;
    end

    // Outputs: head is shown only when valid so the bus reads 0 otherwise
    always_comb begin
        init_done_o          = (r_state == ST_RUN);
        next_empty_ptr_val_o = init_done_o && (r_cnt != '0);
        next_empty_ptr_o     = next_empty_ptr_val_o ? r_mem[r_rd_ptr] : '0;
        empty_ptr_cnt_o      = r_cnt;
        add_err_o            = r_add_err;
        rd_err_o             = r_rd_err;
    end

    // Push/pop decode; a full pool still accepts an add when a pop frees a slot
    always_comb begin
        w_pop     = next_empty_ptr_rd_ack_i && next_empty_ptr_val_o;
        w_push    = (r_state == ST_RUN) && add_empty_ptr_en_i && ((r_cnt != C_DEPTH) || w_pop);
        w_wr_en   = !reinit_i && ((r_state == ST_INIT) || w_push);
        w_wr_data = (r_state == ST_INIT) ? r_init_cnt[A_WIDTH-1:0] : add_empty_ptr_i;
        w_cnt_nxt = r_cnt;
        if (r_state == ST_INIT)
            w_cnt_nxt = r_cnt + (A_WIDTH+1)'(1);
        else if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + (A_WIDTH+1)'(1);
        else if (w_pop && !w_push)
            w_cnt_nxt = r_cnt - (A_WIDTH+1)'(1);
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
    end

    // Pointers, occupancy, preload counter and sticky error flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_cnt      <= '0;
            r_init_cnt <= '0;
            r_add_err  <= 1'b0;
            r_rd_err   <= 1'b0;
        end else if (reinit_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_cnt      <= '0;
            r_init_cnt <= '0;
            r_add_err  <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + A_WIDTH'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + A_WIDTH'(1);
            if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + (A_WIDTH+1)'(1);
            r_cnt <= w_cnt_nxt;
            if (add_empty_ptr_en_i && !w_push)
                r_add_err <= 1'b1;
            if (r_state == ST_RUN && next_empty_ptr_rd_ack_i && !next_empty_ptr_val_o)
                r_rd_err <= 1'b1;
        end
    end

endmodule
